// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency WIDTH+2 cycles (1 for divide-by-zero); in_ready only in IDLE, result held until out_ready.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic               r_sgn, r_sa, r_sb, r_mindiv;
  logic [WIDTH-1:0]   r_a, r_b, r_q;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dz, r_ovf;

  logic               w_accept, w_bz;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow, w_neg;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_res;
  logic               w_ovf;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign dout      = r_dout;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

  assign w_accept = in_valid & in_ready;
  assign w_bz     = (din_b == '0);
  assign w_a_mag  = (sgn & din_a[WIDTH-1]) ? -din_a : din_a;
  assign w_b_mag  = (sgn & din_b[WIDTH-1]) ? -din_b : din_b;

  // Multiply: add multiplicand into the high half when the current LSB is set, then shift right.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};

  // Divide: shift next dividend bit into the partial remainder and try subtracting the divisor.
  assign w_shift  = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
  assign w_borrow = w_diff[WIDTH+1];

  assign w_neg    = r_sgn & (r_sa ^ r_sb);
  assign w_prod_s = w_neg ? -r_acc : r_acc;
  assign w_quo_s  = w_neg ? -r_q : r_q;
  assign w_rem_s  = (r_sgn & r_sa) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_MULLO: begin
        w_res = w_prod_s[WIDTH-1:0];
        w_ovf = r_sgn ? (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}})
                      : (r_acc[2*WIDTH-1:WIDTH] != '0);
      end
      OP_MULHI: w_res = w_prod_s[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        w_res = w_quo_s;
        w_ovf = r_mindiv;
      end
      default:  w_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (op[1] & w_bz) ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0; r_sgn <= 1'b0; r_sa <= 1'b0; r_sb <= 1'b0; r_mindiv <= 1'b0;
      r_a <= '0; r_b <= '0; r_q <= '0; r_acc <= '0; r_rem <= '0; r_cnt <= '0;
      r_dout <= '0; r_dz <= 1'b0; r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op     <= op;
          r_sgn    <= sgn;
          r_sa     <= sgn & din_a[WIDTH-1];
          r_sb     <= sgn & din_b[WIDTH-1];
          r_mindiv <= sgn & (din_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&din_b);
          r_a      <= w_a_mag;
          r_b      <= w_b_mag;
          r_q      <= w_a_mag;
          r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH-1);
          r_ovf    <= 1'b0;
          r_dz     <= op[1] & w_bz;
          // Divide by zero answers straight away: DIV all ones, REM the raw dividend.
          if (op[1] & w_bz) r_dout <= op[0] ? din_a : {WIDTH{1'b1}};
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_op[1]) begin
            r_rem <= w_borrow ? w_shift : w_diff[WIDTH:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_dout <= w_res;
          r_ovf  <= w_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised self-checking bench for mdu_seq against a plain-arithmetic model.
module tb_mdu_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, sgn, out_valid, out_ready, dz, ovf;
  logic [1:0]    op;
  logic [W-1:0]  din_a, din_b, dout;

  int n_checks = 0;
  int n_errors = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sgn(sgn), .din_a(din_a), .din_b(din_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] m_op, input logic m_s, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r, output logic m_dz,
                       output logic m_ovf);
    logic [63:0] p;
    longint      pa, pb;
    m_dz = 1'b0; m_ovf = 1'b0; r = '0;
    if (m_op < 2) begin
      if (m_s) begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = 64'(pa * pb);
        m_ovf = (p != {{32{p[31]}}, p[31:0]});
      end else begin
        p = {32'b0, a} * {32'b0, b};
        m_ovf = (p[63:32] != 32'b0);
      end
      r = (m_op == 2'd0) ? p[31:0] : p[63:32];
      if (m_op == 2'd1) m_ovf = 1'b0;
    end else if (b == 0) begin
      m_dz = 1'b1;
      r = (m_op == 2'd2) ? 32'hFFFF_FFFF : a;
    end else if (m_s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = (m_op == 2'd2) ? 32'h8000_0000 : 32'h0;
        m_ovf = (m_op == 2'd2);
      end else begin
        r = (m_op == 2'd2) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
      end
    end else begin
      r = (m_op == 2'd2) ? a / b : a % b;
    end
  endtask

  // Issue one operation, check latency and result, then consume it after 0..stall cycles.
  task automatic run_op(input logic [1:0] t_op, input logic t_s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W-1:0] er, held;
    logic         edz, eovf;
    int           k;
    model(t_op, t_s, a, b, er, edz, eovf);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = t_op; sgn = t_s; din_a = a; din_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 2'($urandom); sgn = 1'($urandom); din_a = $urandom; din_b = $urandom;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    check("latency", 64'(k), (t_op[1] && b == 0) ? 64'd1 : 64'(W + 2));
    check("dout", 64'(dout), 64'(er));
    check("dz", 64'(dz), 64'(edz));
    check("ovf", 64'(ovf), 64'(eovf));
    held = dout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_dout", 64'(dout), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_dout_kept", 64'(dout), 64'(er));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; sgn = 1'b0;
    din_a = '0; din_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    run_op(2'd0, 1'b0, 32'd7, 32'd6, 0);
    run_op(2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 1'b1, -32'sd7, 32'd2, 0);
    run_op(2'd3, 1'b1, -32'sd7, 32'd2, 0);
    run_op(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 1'b0, 32'd100, 32'd0, 0);
    run_op(2'd3, 1'b0, 32'd100, 32'd0, 0);
    run_op(2'd3, 1'b1, -32'sd9, 32'd0, 0);
    run_op(2'd0, 1'b1, -32'sd3, 32'd5, 10);
    run_op(2'd2, 1'b0, 32'd1000, 32'd7, 10);

    // Abort mid-run with reset, then a fresh multiply must be clean.
    @(negedge clk);
    in_valid = 1'b1; op = 2'd0; sgn = 1'b0; din_a = 32'hDEAD_BEEF; din_b = 32'h1234_5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    run_op(2'd0, 1'b0, 32'd3, 32'd5, 0);

    for (int i = 0; i < 150; i++)
      run_op(2'($urandom), 1'($urandom), pick(), pick(), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
